// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and constants for the truth-table sweep controller.
// The optional first-failure capture is enabled by defining TT_SWEEP_FIRST_FAIL_EN.
package tt_sweep_pkg;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Counter reload value: the settle state lasts cnt+1 cycles.
  function automatic logic [CNT_W-1:0] settle_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if: control/result bundle between a host and the sweep controller.
// The first-failure signals exist only when TT_SWEEP_FIRST_FAIL_EN is defined.
interface tt_sweep_ctrl_if;
  import tt_sweep_pkg::*;

  logic               i_start;
  logic               i_abort;
  logic [NUM_VEC-1:0] i_exp_tt;
  logic               i_s;
  logic [VEC_W-1:0]   o_vec;
  logic               o_busy;
  logic               o_done;
  logic [NUM_VEC-1:0] o_tt;
  logic [4:0]         o_mismatch_cnt;
  logic               o_pass;
`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic               o_first_fail_vld;
  logic [VEC_W-1:0]   o_first_fail_idx;

  modport slave  (input  i_start, i_abort, i_exp_tt, i_s,
                  output o_vec, o_busy, o_done, o_tt, o_mismatch_cnt, o_pass,
                         o_first_fail_vld, o_first_fail_idx);
  modport master (output i_start, i_abort, i_exp_tt, i_s,
                  input  o_vec, o_busy, o_done, o_tt, o_mismatch_cnt, o_pass,
                         o_first_fail_vld, o_first_fail_idx);
`else
  modport slave  (input  i_start, i_abort, i_exp_tt, i_s,
                  output o_vec, o_busy, o_done, o_tt, o_mismatch_cnt, o_pass);
  modport master (output i_start, i_abort, i_exp_tt, i_s,
                  input  o_vec, o_busy, o_done, o_tt, o_mismatch_cnt, o_pass);
`endif

endinterface

// File: rtl/tt_sweep_ctrl_settle_cnt.sv
// tt_settle_cnt: loadable down-counter timing how long each vector is held.
// o_zero flags that the current settle interval has elapsed.
module tt_settle_cnt
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [CNT_W-1:0] LP_LOAD = settle_load(SETTLE_CYC);

  logic [CNT_W-1:0] r_cnt;

  // Load on a new vector, otherwise count down towards zero and stop there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= LP_LOAD;
    end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: walks all 16 input vectors of a 4-input gate block, samples its
// output after a settle interval and compares the captured truth table against
// an expected table latched at start.
// Define TT_SWEEP_FIRST_FAIL_EN to add first-mismatch index capture.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input logic         clk,
  input logic         rst,
  tt_sweep_ctrl_if.slave bus
);

  localparam logic [VEC_W-1:0] LP_LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_e             r_state;
  state_e             w_next;
  logic               w_accept;
  logic               w_load;
  logic               w_dec;
  logic               w_sample;
  logic               w_abort;
  logic               w_zero;
  logic               w_mis;

  logic [VEC_W-1:0]   r_vec;
  logic               r_busy;
  logic               r_done;
  logic [NUM_VEC-1:0] r_tt;
  logic [NUM_VEC-1:0] r_exp_q;
  logic [4:0]         r_mismatch_cnt;
  logic               r_pass;
`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic               r_ff_vld;
  logic [VEC_W-1:0]   r_ff_idx;
`endif

  tt_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  assign w_mis = (bus.i_s != r_exp_q[r_vec]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-cycle control strobes; abort beats start and sample.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_sample = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          w_next   = SETTLE;
          w_accept = 1'b1;
          w_load   = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      SETTLE: begin
        if (bus.i_abort) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end else if (w_zero) begin
          w_next = SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (bus.i_abort) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end else if (r_vec == LP_LAST_VEC) begin
          w_sample = 1'b1;
          w_next   = DONE;
        end else begin
          w_sample = 1'b1;
          w_load   = 1'b1;
          w_next   = SETTLE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Vector stepping, truth-table capture, mismatch counting and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec          <= {VEC_W{1'b0}};
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_tt           <= {NUM_VEC{1'b0}};
      r_exp_q        <= {NUM_VEC{1'b0}};
      r_mismatch_cnt <= 5'd0;
      r_pass         <= 1'b0;
`ifdef TT_SWEEP_FIRST_FAIL_EN
      r_ff_vld       <= 1'b0;
      r_ff_idx       <= {VEC_W{1'b0}};
`endif
    end else begin
      r_busy <= (w_next == SETTLE) || (w_next == SAMPLE);
      r_done <= (r_state == DONE);
      if (w_accept) begin
        r_vec          <= {VEC_W{1'b0}};
        r_tt           <= {NUM_VEC{1'b0}};
        r_exp_q        <= bus.i_exp_tt;
        r_mismatch_cnt <= 5'd0;
        r_pass         <= 1'b0;
`ifdef TT_SWEEP_FIRST_FAIL_EN
        r_ff_vld       <= 1'b0;
        r_ff_idx       <= {VEC_W{1'b0}};
`endif
      end else if (w_sample) begin
        r_tt[r_vec] <= bus.i_s;
        if (w_mis) begin
          r_mismatch_cnt <= r_mismatch_cnt + 5'd1;
        end else begin
          r_mismatch_cnt <= r_mismatch_cnt;
        end
`ifdef TT_SWEEP_FIRST_FAIL_EN
        if (w_mis && !r_ff_vld) begin
          r_ff_vld <= 1'b1;
          r_ff_idx <= r_vec;
        end else begin
          r_ff_vld <= r_ff_vld;
        end
`endif
        // The last vector stays on vec until the DONE state returns it to 0.
        if (r_vec != LP_LAST_VEC) begin
          r_vec <= r_vec + {{(VEC_W-1){1'b0}}, 1'b1};
        end else begin
          r_vec <= r_vec;
        end
      end else if (w_abort) begin
        r_vec  <= {VEC_W{1'b0}};
        r_pass <= 1'b0;
      end else if (r_state == DONE) begin
        r_vec  <= {VEC_W{1'b0}};
        r_pass <= (r_mismatch_cnt == 5'd0);
      end else begin
        r_vec <= r_vec;
      end
    end
  end

  assign bus.o_vec          = r_vec;
  assign bus.o_busy         = r_busy;
  assign bus.o_done         = r_done;
  assign bus.o_tt           = r_tt;
  assign bus.o_mismatch_cnt = r_mismatch_cnt;
  assign bus.o_pass         = r_pass;
`ifdef TT_SWEEP_FIRST_FAIL_EN
  assign bus.o_first_fail_vld = r_ff_vld;
  assign bus.o_first_fail_idx = r_ff_idx;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: scoreboard bench for tt_sweep_ctrl with a behavioural model
// of the block under test driving s from the applied vector.
module tb_tt_sweep_ctrl;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  mm;
    logic        pass;
    logic        ffv;
    logic [3:0]  ffi;
  } exp_t;

  logic clk;
  logic rst;
  logic [1:0] model_sel;
  int n_total;
  int n_bad;
  exp_t sb_q[$];

  tt_sweep_ctrl_if u_if ();

  tt_sweep_ctrl #(.SETTLE_CYC(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the gate block: 0 -> s=a, 1 -> s=0, 2 -> s=d.
  function automatic logic s_of(input logic [1:0] m, input logic [3:0] v);
    case (m)
      2'd0:    return v[3];
      2'd1:    return 1'b0;
      2'd2:    return v[0];
      default: return 1'b0;
    endcase
  endfunction

  always_comb u_if.i_s = s_of(model_sel, u_if.o_vec);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One full sweep; optional start re-pulse and exp_tt change mid-sweep.
  task automatic run_sweep(input logic [1:0] m, input logic [15:0] exp_tt,
                           input int restart_k, input int exp_chg_k);
    exp_t e;
    exp_t got_e;
    int k;
    int errs;
    logic got;
    e.tt = 16'h0000;
    e.mm = 5'd0;
    e.ffv = 1'b0;
    e.ffi = 4'd0;
    for (int i = 0; i < 16; i++) begin
      e.tt[i] = s_of(m, 4'(i));
      if (e.tt[i] != exp_tt[i]) begin
        e.mm = e.mm + 5'd1;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = 4'(i);
        end
      end
    end
    e.pass = (e.mm == 5'd0);
    sb_q.push_back(e);

    @(negedge clk);
    model_sel = m;
    u_if.i_exp_tt = exp_tt;
    u_if.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    errs = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      u_if.i_start = (k == restart_k);
      if (k == exp_chg_k) u_if.i_exp_tt = ~u_if.i_exp_tt;
      if (k <= 47) begin
        if (32'(u_if.o_vec) != k / 3 || u_if.o_busy !== 1'b1) errs++;
      end else if (k == 48) begin
        if (u_if.o_busy !== 1'b0) errs++;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      if (u_if.o_done === 1'b1) got = 1'b1;
    end
    u_if.i_start = 1'b0;
    chk("latency", k, 49);
    chk("vec_seq", errs, 0);
    if (sb_q.size() > 0) begin
      got_e = sb_q.pop_front();
      chk("tt", u_if.o_tt, got_e.tt);
      chk("mismatch_cnt", u_if.o_mismatch_cnt, got_e.mm);
      chk("pass", u_if.o_pass, got_e.pass);
`ifdef TT_SWEEP_FIRST_FAIL_EN
      chk("ff_vld", u_if.o_first_fail_vld, got_e.ffv);
      chk("ff_idx", u_if.o_first_fail_idx, got_e.ffi);
`endif
    end else begin
      chk("sb_empty", 32'd1, 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", u_if.o_done, 1'b0);
    chk("vec_idle", u_if.o_vec, 4'd0);
    chk("hold_tt", u_if.o_tt, e.tt);
  endtask

  // Wait (bounded) for a given vector at a falling edge.
  task automatic wait_vec(input logic [3:0] v, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (u_if.o_vec == v && u_if.o_busy === 1'b1) ok = 1'b1;
    end
  endtask

  initial begin
    logic ok;
    int dcnt;
    n_total = 0;
    n_bad = 0;
    model_sel = 2'd0;
    u_if.i_start = 1'b0;
    u_if.i_abort = 1'b0;
    u_if.i_exp_tt = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vec", u_if.o_vec, 4'd0);
    chk("rst_busy", u_if.o_busy, 1'b0);
    chk("rst_done", u_if.o_done, 1'b0);
    chk("rst_tt", u_if.o_tt, 16'h0000);
    chk("rst_mm", u_if.o_mismatch_cnt, 5'd0);
    chk("rst_pass", u_if.o_pass, 1'b0);
    rst = 1'b0;

    run_sweep(2'd0, 16'hFF00, -1, -1);
    run_sweep(2'd0, 16'hFF01, -1, -1);
    run_sweep(2'd1, 16'hFFFF, -1, -1);
    run_sweep(2'd0, 16'hFF00, 10, 12);
    run_sweep(2'd0, 16'hF740, -1, -1);

    // Abort when vec==5 with s=d: vectors 0..4 captured as 5'b01010.
    @(negedge clk);
    model_sel = 2'd2;
    u_if.i_exp_tt = 16'h0000;
    u_if.i_start = 1'b1;
    @(negedge clk);
    u_if.i_start = 1'b0;
    wait_vec(4'd5, ok);
    chk("abort_reach", ok, 1'b1);
    u_if.i_abort = 1'b1;
    @(negedge clk);
    u_if.i_abort = 1'b0;
    chk("abort_busy", u_if.o_busy, 1'b0);
    chk("abort_vec", u_if.o_vec, 4'd0);
    chk("abort_tt", u_if.o_tt, 16'h000A);
    chk("abort_mm", u_if.o_mismatch_cnt, 5'd2);
    chk("abort_pass", u_if.o_pass, 1'b0);
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (u_if.o_done === 1'b1 || u_if.o_busy === 1'b1) dcnt++;
    end
    chk("abort_quiet", dcnt, 0);

    // Start and abort together in IDLE: no sweep, partial results untouched.
    u_if.i_start = 1'b1;
    u_if.i_abort = 1'b1;
    @(negedge clk);
    u_if.i_start = 1'b0;
    u_if.i_abort = 1'b0;
    chk("sa_busy", u_if.o_busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("sa_vec", u_if.o_vec, 4'd0);
    chk("sa_tt", u_if.o_tt, 16'h000A);

    // Asynchronous reset while vec==9.
    model_sel = 2'd0;
    u_if.i_exp_tt = 16'h0000;
    u_if.i_start = 1'b1;
    @(negedge clk);
    u_if.i_start = 1'b0;
    wait_vec(4'd9, ok);
    chk("rst_reach", ok, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vec", u_if.o_vec, 4'd0);
    chk("arst_busy", u_if.o_busy, 1'b0);
    chk("arst_tt", u_if.o_tt, 16'h0000);
    chk("arst_mm", u_if.o_mismatch_cnt, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(2'd0, 16'hFF00, -1, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a 4-input combinational gate block (a, b, c, d -> s) in hardware.
- Drives all 16 input vectors in order, waits a settle interval for each, and samples s.
- Builds a 16-bit truth table and compares it against an expected table latched at start.
- Sits beside the gate-level exercise modules as their self-check controller; replaces per-vector manual stimulus.

Parameters:
- SETTLE_CYC, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to begin a sweep; ignored while busy.
- abort  input  1  cancels a sweep in progress.
- exp_tt  input  16  expected truth table; bit i = expected s for vector i; latched on accepted start.
- s  input  1  output of the block under test.
- vec  output  4  applied vector {a,b,c,d}; a = vec[3] (MSB), d = vec[0].
- busy  output  1  high from accepted start until the DONE state or an abort.
- done  output  1  one-cycle pulse when a sweep completes.
- tt  output  16  captured truth table; bit i = sampled s for vector i.
- mismatch_cnt  output  5  number of bits where tt differs from the latched exp_tt (0..16).
- pass  output  1  high when the last completed sweep had mismatch_cnt == 0.

Behaviour:
- Reset (async, rst=1): state=IDLE, vec=0, busy=0, done=0, tt=0, mismatch_cnt=0, pass=0, settle counter=0, exp register=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 -> SETTLE; vec=0, cnt=SETTLE_CYC-1, tt=0, mismatch_cnt=0, pass=0, exp_q=exp_tt.
  - start=1 and abort=1 in the same cycle -> abort wins; stay IDLE.
- SETTLE: cnt==0 -> SAMPLE; otherwise cnt decrements. vec is held stable. The state lasts exactly SETTLE_CYC cycles.
- SAMPLE (one cycle): at the closing edge, tt[vec] <= s; if s != exp_q[vec] then mismatch_cnt increments.
  - vec==15 -> DONE.
  - Otherwise vec <= vec+1, cnt <= SETTLE_CYC-1, -> SETTLE.
- DONE (one cycle): done=1, busy=0, pass = (mismatch_cnt==0); then -> IDLE.
- vec returns to 0 in IDLE; vec increments from 15 never occur (no wrap inside a sweep).
- Latency: done rises 16*(SETTLE_CYC+1)+1 cycles after the edge accepting start (49 for the default).
- busy=1 in SETTLE and SAMPLE only.
- start while busy: ignored, with no effect on state or the latched exp_q.
- abort in SETTLE or SAMPLE:
  - Next edge -> IDLE, vec=0, busy=0, no done pulse, pass=0.
  - tt and mismatch_cnt keep their partial values; a sample coinciding with abort is discarded.
- tt, mismatch_cnt and pass hold after DONE until the next accepted start.
- rst mid-sweep: immediate return to reset values; no done.
- Changes on exp_tt after start have no effect.

Optional Feature:
- Macro: TT_SWEEP_FIRST_FAIL_EN.
- Defined:
  - Adds outputs first_fail_vld (1 bit) and first_fail_idx (4 bits); both reset to 0 and clear on accepted start.
  - On the first mismatching SAMPLE of a sweep: first_fail_vld=1 and first_fail_idx=vec; later mismatches do not overwrite them.
  - Both hold after DONE or abort.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package tt_sweep_pkg holds:
  - state enum type (IDLE, SETTLE, SAMPLE, DONE);
  - constants NUM_VEC=16, VEC_W=4, CNT_W=5.
- One sub-module, tt_settle_cnt: a loadable down-counter with a zero flag, SETTLE_CYC load value.
- Comparator and table capture stay in the top level.

Test Plan:
- Model s = vec[3]; exp_tt=16'hFF00, start pulse -> vec steps 0..15, each held 2 cycles then sampled; done at cycle 49; tt=16'hFF00, mismatch_cnt=0, pass=1.
- Same model, exp_tt=16'hFF01 -> mismatch_cnt=1, pass=0; with TT_SWEEP_FIRST_FAIL_EN: first_fail_vld=1, first_fail_idx=0.
- Model s=0, exp_tt=16'hFFFF -> mismatch_cnt=16 (5-bit, no overflow), tt=16'h0000.
- Pulse start again at cycle 10 of a sweep, and change exp_tt mid-sweep -> neither has any effect; results are identical to the first scenario.
- Abort when vec==5 -> IDLE next edge, vec=0, no done, tt[4:0] retained; start+abort together in IDLE -> stays IDLE.
- Assert rst when vec==9 -> all outputs zero asynchronously; a subsequent start runs a full sweep normally.
